// File: rtl/prio_enc_rr.sv
// Registered N-way request encoder with sticky pending bits and a valid/ready output.
// Selection is fixed-priority (highest index) or round-robin from the last grant.
module prio_enc_rr #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         mode_rr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] sel;
  logic [N-1:0] sel_onehot;
  logic         found;
  logic         load;
  int           rr_j;

  // Selection looks only at registered pending, never at req_i.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    rr_j  = 0;
    if (mode_rr) begin
      for (int i = 1; i <= N; i++) begin
        rr_j = int'(ptr_q) + i;
        if (rr_j >= N) rr_j = rr_j - N;
        if (!found && pending_q[rr_j[W-1:0]]) begin
          sel   = rr_j[W-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) sel = W'(i);
      end
    end
  end

  assign sel_onehot = N'(1) << sel;
  assign load       = (|pending_q) && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    ptr_d        = ptr_q;
    // A fresh request for the bit being granted this edge keeps it pending.
    pending_d    = (pending_q & ~(load ? sel_onehot : '0)) | req_i;
    if (load) begin
      out_valid_d  = 1'b1;
      out_idx_d    = sel;
      out_onehot_d = sel_onehot;
      ptr_d        = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_idx_d    = '0;
      out_onehot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= W'(N - 1);
    end else begin
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed bench for prio_enc_rr (N=8): reset, fixed priority, round-robin wrap,
// backpressure, re-request of an in-flight index and reset mid-operation.
module tb_prio_enc_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_i = 8'h00;
  logic       mode_rr = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  prio_enc_rr #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .mode_rr   (mode_rr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_onehot(out_onehot),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are then checked and inputs driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = 8'h00; out_ready = 1'b1; mode_rr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 8'hFF; mode_rr = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({out_valid, out_idx, out_onehot, pending} !== {1'b0, 3'd0, 8'h00, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got v=%b idx=%0d oh=%h pend=%h, expected all zero",
                 c, out_valid, out_idx, out_onehot, pending);
      end
    end
    rst = 1'b0; req_i = 8'h01;
    tick();
    req_i = 8'h00;
    n_checks++;
    if ({out_valid, pending} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL reset_first_req_pending: got v=%b pend=%h, expected v=0 pend=01", out_valid, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd0, 8'h01, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=0 oh=01 pend=00",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot} !== {1'b0, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_drain: got v=%b idx=%0d oh=%h, expected zeros", out_valid, out_idx, out_onehot);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode_rr = 1'b0; out_ready = 1'b1; req_i = 8'b0010_0001;
    tick();
    req_i = 8'h00;
    n_checks++;
    if ({out_valid, pending} !== {1'b0, 8'h21}) begin
      n_fail++;
      $display("FAIL fixed_pending: got v=%b pend=%h, expected v=0 pend=21", out_valid, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd5, 8'h20, 8'h01}) begin
      n_fail++;
      $display("FAIL fixed_first: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=5 oh=20 pend=01",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd0, 8'h01, 8'h00}) begin
      n_fail++;
      $display("FAIL fixed_second: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=0 oh=01 pend=00",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b0, 3'd0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL fixed_idle: got v=%b idx=%0d oh=%h pend=%h, expected zeros",
               out_valid, out_idx, out_onehot, pending);
    end
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
    do_reset();
    mode_rr = 1'b1; out_ready = 1'b1; req_i = 8'hFF;
    tick();
    n_checks++;
    if ({out_valid, pending} !== {1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL rr_pending: got v=%b pend=%h, expected v=0 pend=ff", out_valid, pending);
    end
    for (int g = 0; g < 10; g++) begin
      tick();
      exp_idx = 3'(g % 8);
      exp_oh  = 8'h01 << exp_idx;
      n_checks++;
      if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, exp_idx, exp_oh, 8'hFF}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=%0d oh=%h pend=ff",
                 g, out_valid, out_idx, out_onehot, pending, exp_idx, exp_oh);
      end
    end
    req_i = 8'h00;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode_rr = 1'b0; out_ready = 1'b1; req_i = 8'h08;
    tick();
    req_i = 8'h00; out_ready = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_idx, pending} !== {1'b1, 3'd3, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_setup: got v=%b idx=%0d pend=%h, expected v=1 idx=3 pend=00", out_valid, out_idx, pending);
    end
    req_i = 8'h40;
    tick();
    req_i = 8'h00;
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd3, 8'h08, 8'h40}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=3 oh=08 pend=40",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, pending} !== {1'b1, 3'd3, 8'h40}) begin
      n_fail++;
      $display("FAIL bp_hold2: got v=%b idx=%0d pend=%h, expected v=1 idx=3 pend=40", out_valid, out_idx, pending);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd6, 8'h40, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=6 oh=40 pend=00",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx} !== {1'b1, 3'd6}) begin
      n_fail++;
      $display("FAIL bp_stall_again: got v=%b idx=%0d, expected v=1 idx=6", out_valid, out_idx);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_rerequest();
    do_reset();
    mode_rr = 1'b0; out_ready = 1'b1; req_i = 8'h04;
    tick();
    req_i = 8'h00; out_ready = 1'b0;
    tick();
    req_i = 8'h04;
    tick();
    req_i = 8'h00;
    n_checks++;
    if ({out_valid, out_idx, pending} !== {1'b1, 3'd2, 8'h04}) begin
      n_fail++;
      $display("FAIL rereq_queued: got v=%b idx=%0d pend=%h, expected v=1 idx=2 pend=04", out_valid, out_idx, pending);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd2, 8'h04, 8'h00}) begin
      n_fail++;
      $display("FAIL rereq_reissue: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=2 oh=04 pend=00",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rereq_done: got v=%b, expected v=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode_rr = 1'b1; out_ready = 1'b1; req_i = 8'h10;
    tick();
    req_i = 8'h00; out_ready = 1'b0;
    tick();
    req_i = 8'h81;
    tick();
    n_checks++;
    if ({out_valid, out_idx, pending} !== {1'b1, 3'd4, 8'h81}) begin
      n_fail++;
      $display("FAIL mid_setup: got v=%b idx=%0d pend=%h, expected v=1 idx=4 pend=81", out_valid, out_idx, pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b0, 3'd0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b idx=%0d oh=%h pend=%h, expected zeros",
               out_valid, out_idx, out_onehot, pending);
    end
    out_ready = 1'b1;
    tick();
    req_i = 8'h00;
    n_checks++;
    if ({out_valid, pending} !== {1'b0, 8'h81}) begin
      n_fail++;
      $display("FAIL mid_pending: got v=%b pend=%h, expected v=0 pend=81", out_valid, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, pending} !== {1'b1, 3'd0, 8'h80}) begin
      n_fail++;
      $display("FAIL mid_rr_first: got v=%b idx=%0d pend=%h, expected v=1 idx=0 pend=80", out_valid, out_idx, pending);
    end
    tick();
    n_checks++;
    if ({out_valid, out_idx, out_onehot, pending} !== {1'b1, 3'd7, 8'h80, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_rr_second: got v=%b idx=%0d oh=%h pend=%h, expected v=1 idx=7 oh=80 pend=00",
               out_valid, out_idx, out_onehot, pending);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: got v=%b, expected v=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_backpressure();
    test_rerequest();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
